sms32_sbox_layer_seq: RTL



---
 rtl/sms32_sbox_layer_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/sms32_sbox_layer_seq.sv
// sms32_sbox_layer_seq: sequential S-box layer, x^26 over GF(2^6) mod x^6+x+1, LANES words per beat.
// Optional macro SMS32_LAYER_CNT_EN adds a saturating completed-layer counter output.
`timescale 1ns/1ps
module sms32_sbox_layer_seq #(
    parameter int N_WORDS = 8,
    parameter int LANES   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6*N_WORDS-1:0]   in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6*N_WORDS-1:0]   out_state,
    output logic                   busy
`ifdef SMS32_LAYER_CNT_EN
    ,
    output logic [15:0]            layer_cnt
`endif
);
    localparam int NB = N_WORDS / LANES;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LANES < 1 || N_WORDS % LANES != 0) begin : g_bad_lanes
        $error("LANES must divide N_WORDS");
    end

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[4:0], 1'b0} ^ (t[5] ? 6'h03 : 6'h00);
        end
        return p;
    endfunction

    // x^26 = x^16 * x^8 * x^2 via a square chain
    function automatic logic [5:0] sbox(input logic [5:0] x);
        logic [5:0] x2, x4, x8, x16;
        x2  = gf_mul(x, x);
        x4  = gf_mul(x2, x2);
        x8  = gf_mul(x4, x4);
        x16 = gf_mul(x8, x8);
        return gf_mul(gf_mul(x16, x8), x2);
    endfunction

    logic [1:0]           st_q, st_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [6*N_WORDS-1:0] state_q, state_d;
    logic                 last;

    assign last      = cnt_q == CW'(NB - 1);
    assign in_ready  = st_q == IDLE;
    assign busy      = st_q == RUN;
    assign out_valid = st_q == DONE;
    assign out_state = state_q;

    // Next state: load on accept, substitute one beat of words per RUN cycle, release on drain
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (st_q == IDLE && in_valid) begin
            state_d = in_state;
            cnt_d   = '0;
            st_d    = RUN;
        end
        if (st_q == RUN) begin
            for (int l = 0; l < LANES; l++)
                state_d[6*(int'(cnt_q)*LANES+l) +: 6] = sbox(state_q[6*(int'(cnt_q)*LANES+l) +: 6]);
            cnt_d = last ? '0 : cnt_q + 1'b1;
            st_d  = last ? DONE : RUN;
        end
        if (st_q == DONE && out_ready) st_d = IDLE;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

`ifdef SMS32_LAYER_CNT_EN
    logic [15:0] layer_cnt_q;
    assign layer_cnt = layer_cnt_q;

    // Count drained layers, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            layer_cnt_q <= '0;
        else if (out_valid && out_ready && layer_cnt_q != 16'hFFFF)
            layer_cnt_q <= layer_cnt_q + 16'd1;
    end
`endif
endmodule
